// File: rtl/font_pkg.sv
// Glyph table for the 4x8 text-mode character generator.
// Column x=3 is always blank in printable glyphs so adjacent cells keep a 1-pixel gap.
package font_pkg;
  localparam int CH_WIDTH   = 4;
  localparam int CH_HEIGHT  = 8;
  localparam int GLYPH_BITS = CH_WIDTH * CH_HEIGHT;

  localparam logic [GLYPH_BITS-1:0] GLYPH_BLANK      = 32'h0000_0000;
  localparam logic [GLYPH_BITS-1:0] GLYPH_SOLID      = 32'hFFFF_FFFF;
  localparam logic [GLYPH_BITS-1:0] GLYPH_DASH       = 32'h0000_7000;
  localparam logic [GLYPH_BITS-1:0] GLYPH_UNDERSCORE = 32'h7000_0000;

  // Art is written one octal digit per row, top row first, digit MSB = leftmost pixel,
  // so the literal reads like the picture; this repacks it to glyph[y*4+x].
  function automatic logic [GLYPH_BITS-1:0] rows(input logic [23:0] r);
    logic [GLYPH_BITS-1:0] g;
    g = '0;
    for (int y = 0; y < CH_HEIGHT; y++)
      for (int x = 0; x < CH_WIDTH - 1; x++)
        g[y*CH_WIDTH + x] = r[23 - 3*y - x];
    return g;
  endfunction

  function automatic logic [GLYPH_BITS-1:0] font_lookup(input logic [7:0] code);
    logic [GLYPH_BITS-1:0] g;
    case (code)
      8'h21: g = rows(24'o22220200);  8'h22: g = rows(24'o55000000);
      8'h23: g = rows(24'o57575000);  8'h24: g = rows(24'o27471720);
      8'h25: g = rows(24'o51245000);  8'h26: g = rows(24'o25275700);
      8'h27: g = rows(24'o22000000);  8'h28: g = rows(24'o12444210);
      8'h29: g = rows(24'o42111240);  8'h2A: g = rows(24'o05272500);
      8'h2B: g = rows(24'o02272200);  8'h2C: g = rows(24'o00000224);
      8'h2D: g = GLYPH_DASH;          8'h2E: g = rows(24'o00000200);
      8'h2F: g = rows(24'o11224400);
      8'h30: g = rows(24'o75555570);  8'h31: g = rows(24'o26222270);
      8'h32: g = rows(24'o71174470);  8'h33: g = rows(24'o71171170);
      8'h34: g = rows(24'o55571110);  8'h35: g = rows(24'o74471170);
      8'h36: g = rows(24'o74475570);  8'h37: g = rows(24'o71122220);
      8'h38: g = rows(24'o75575570);  8'h39: g = rows(24'o75571170);
      8'h3A: g = rows(24'o02000200);  8'h3B: g = rows(24'o02000224);
      8'h3C: g = rows(24'o01242100);  8'h3D: g = rows(24'o00707000);
      8'h3E: g = rows(24'o04212400);  8'h3F: g = rows(24'o71132020);
      8'h40: g = rows(24'o25774300);
      8'h41: g = rows(24'o25575550);  8'h42: g = rows(24'o65565560);
      8'h43: g = rows(24'o34444430);  8'h44: g = rows(24'o65555560);
      8'h45: g = rows(24'o74464470);  8'h46: g = rows(24'o74464440);
      8'h47: g = rows(24'o34455530);  8'h48: g = rows(24'o55575550);
      8'h49: g = rows(24'o72222270);  8'h4A: g = rows(24'o11111520);
      8'h4B: g = rows(24'o55646550);  8'h4C: g = rows(24'o44444470);
      8'h4D: g = rows(24'o57755550);  8'h4E: g = rows(24'o65555550);
      8'h4F: g = rows(24'o25555520);  8'h50: g = rows(24'o65564440);
      8'h51: g = rows(24'o25555730);  8'h52: g = rows(24'o65565550);
      8'h53: g = rows(24'o34421160);  8'h54: g = rows(24'o72222220);
      8'h55: g = rows(24'o55555570);  8'h56: g = rows(24'o55555520);
      8'h57: g = rows(24'o55557750);  8'h58: g = rows(24'o55525550);
      8'h59: g = rows(24'o55522220);  8'h5A: g = rows(24'o71124470);
      8'h5B: g = rows(24'o64444460);  8'h5C: g = rows(24'o44221100);
      8'h5D: g = rows(24'o31111130);  8'h5E: g = rows(24'o25000000);
      8'h5F: g = GLYPH_UNDERSCORE;    8'h60: g = rows(24'o42000000);
      8'h61: g = rows(24'o00617570);  8'h62: g = rows(24'o44655560);
      8'h63: g = rows(24'o00344430);  8'h64: g = rows(24'o11355530);
      8'h65: g = rows(24'o00257430);  8'h66: g = rows(24'o12722220);
      8'h67: g = rows(24'o00355316);  8'h68: g = rows(24'o44655550);
      8'h69: g = rows(24'o20622270);  8'h6A: g = rows(24'o10111152);
      8'h6B: g = rows(24'o44566550);  8'h6C: g = rows(24'o62222270);
      8'h6D: g = rows(24'o00577550);  8'h6E: g = rows(24'o00655550);
      8'h6F: g = rows(24'o00255520);  8'h70: g = rows(24'o00655644);
      8'h71: g = rows(24'o00355311);  8'h72: g = rows(24'o00564440);
      8'h73: g = rows(24'o00342160);  8'h74: g = rows(24'o22722210);
      8'h75: g = rows(24'o00555530);  8'h76: g = rows(24'o00555520);
      8'h77: g = rows(24'o00557750);  8'h78: g = rows(24'o00552550);
      8'h79: g = rows(24'o00555316);  8'h7A: g = rows(24'o00712470);
      8'h7B: g = rows(24'o12242210);  8'h7C: g = rows(24'o22222220);
      8'h7D: g = rows(24'o42212240);  8'h7E: g = rows(24'o00630000);
      8'hFF: g = GLYPH_SOLID;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction
endpackage

// File: rtl/font_rom.sv
// Character-generator ROM: one-cycle registered glyph lookup with hold-on-disable.
module font_rom
  import font_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            ch_code,
  input  logic                  ch_en,
  output logic [GLYPH_BITS-1:0] glyph
);
  always_ff @(posedge clk) begin
    if (rst)        glyph <= GLYPH_BLANK;
    else if (ch_en) glyph <= font_lookup(ch_code);
  end
endmodule

// File: tb/tb_font_rom.sv
// Directed + randomized bench for font_rom against a cycle-level behavioural model.
module tb_font_rom;
  import font_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ch_code = 8'h00;
  logic        ch_en = 1'b0;
  logic [31:0] glyph;

  int checks = 0;
  int errors = 0;
  logic [31:0] model = 32'h0;
  logic [31:0] seen [256];

  font_rom dut (.clk(clk), .rst(rst), .ch_code(ch_code), .ch_en(ch_en), .glyph(glyph));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model by the rules, sample just after the edge.
  task automatic step(input logic r, input logic en, input logic [7:0] code);
    @(negedge clk);
    rst = r; ch_en = en; ch_code = code;
    @(posedge clk);
    #1;
    if (r)       model = 32'h0;
    else if (en) model = font_lookup(code);
  endtask

  function automatic logic [31:0] class_expect(input logic [7:0] c);
    if (c == 8'hFF) return 32'hFFFF_FFFF;
    return 32'h0;
  endfunction

  initial begin
    step(1'b1, 1'b0, 8'h00);
    check("reset", glyph, 32'h0);

    step(1'b0, 1'b1, 8'hFF);
    check("solid_pre", glyph, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 8'hFF);
    check("reset_prio", glyph, 32'h0);
    step(1'b0, 1'b1, 8'hFF);
    check("post_reset", glyph, 32'hFFFF_FFFF);

    step(1'b0, 1'b1, 8'h2D); check("lat_dash", glyph, 32'h0000_7000);
    step(1'b0, 1'b1, 8'h5F); check("lat_under", glyph, 32'h7000_0000);
    step(1'b0, 1'b1, 8'h20); check("lat_space", glyph, 32'h0);
    step(1'b0, 1'b1, 8'hFF); check("lat_solid", glyph, 32'hFFFF_FFFF);

    step(1'b0, 1'b1, 8'h2D);
    for (int c = 0; c < 256; c++) begin
      step(1'b0, 1'b0, 8'(c));
      check("hold", glyph, 32'h0000_7000);
    end

    for (int c = 0; c < 256; c++) begin
      step(1'b0, 1'b1, 8'(c));
      seen[c] = glyph;
      check("sweep_model", glyph, model);
      if (c >= 8'h21 && c <= 8'h7E) begin
        check("printable_nz", 32'(glyph != 32'h0), 32'h1);
        check("gap_col", glyph & 32'h8888_8888, 32'h0);
      end else begin
        check("blank_or_solid", glyph, class_expect(8'(c)));
      end
    end

    for (int i = 0; i < 26; i++)
      check("case_distinct", 32'(seen[8'h41+i] !== seen[8'h61+i]), 32'h1);
    for (int i = 0; i < 10; i++)
      for (int j = i + 1; j < 10; j++)
        check("digit_distinct", 32'(seen[8'h30+i] !== seen[8'h30+j]), 32'h1);

    step(1'b0, 1'b1, 8'h2D);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 4; x++)
        check("pixel_dash", 32'(glyph[y*4+x]), 32'((y == 3 && x < 3) ? 1 : 0));

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(15) == 0), $urandom_range(1) == 1, 8'($urandom_range(255)));
      check("random", glyph, model);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
